// File: rtl/vrp_pld_fifo.sv
// ---------------------------------------------------------------------------
// vrp_pld_fifo
//
// Synchronous valid/ready payload FIFO that sits in front of one source
// input of the vrp_arb fixed-priority arbiter. It absorbs back-pressure
// while the arbiter serves other sources. It also keeps the arbiter's
// combinational grant path from reaching back into the source.
//
// Handshake semantics (both sides): a beat transfers on a rising clock edge
// where valid and ready are both high. A valid beat holds its payload
// until it is accepted. Neither valid nor ready on the master side depends
// combinationally on rdy_m.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//   PLD_WIDTH  payload width in bits
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset
//   vld_s  in   upstream payload valid
//   pld_s  in   upstream payload
//   rdy_s  out  FIFO accepts pld_s this cycle
//   vld_m  out  head entry valid (to arbiter v_vld_s[i])
//   pld_m  out  head payload     (to arbiter v_pld_s[i])
//   rdy_m  in   arbiter grant    (from arbiter v_rdy_s[i])
//   count  out  occupancy 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
//
// Build option:
//   VRP_PLD_FIFO_BYPASS_EN  when defined, a beat arriving at an empty FIFO
//                           is presented on the master side in the same
//                           cycle. It passes straight through if rdy_m is
//                           high. Otherwise it is stored as a normal push.
// ---------------------------------------------------------------------------
module vrp_pld_fifo #(
  parameter int DEPTH     = 4,
  parameter int PLD_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vld_s,
  input  logic [PLD_WIDTH-1:0]       pld_s,
  output logic                       rdy_s,
  output logic                       vld_m,
  output logic [PLD_WIDTH-1:0]       pld_m,
  input  logic                       rdy_m,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage is deliberately not reset; validity is tracked by the pointers.
  logic [PLD_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          push;
  logic          pop;
  logic [PLD_WIDTH-1:0] head;

  // -------------------------------------------------------------------------
  // Status, derived purely from registered pointers
  // -------------------------------------------------------------------------
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    count = wr_ptr - rd_ptr;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // Upstream ready depends only on reset and occupancy, never on rdy_m.
  // When full, a pop in the same cycle does not open a slot until the
  // next cycle.
  assign rdy_s = rst_n && !full;

  // -------------------------------------------------------------------------
  // Master-side presentation and handshake qualification
  // -------------------------------------------------------------------------
`ifdef VRP_PLD_FIFO_BYPASS_EN
  logic pass_thru;

  // vld_m may follow vld_s combinationally when empty. It still never
  // looks at rdy_m, so the arbiter grant cannot loop back into it.
  always_comb begin
    vld_m     = rst_n && (!empty || vld_s);
    pld_m     = empty ? pld_s : head;
    // A beat consumed directly from the input never touches storage.
    pass_thru = empty && vld_s && rdy_m && rst_n;
    push      = vld_s && rdy_s && !pass_thru;
    pop       = rst_n && !empty && rdy_m;
  end
`else
  always_comb begin
    vld_m = rst_n && !empty;
    pld_m = head;
    push  = vld_s && rdy_s;
    pop   = vld_m && rdy_m;
  end
`endif

  // -------------------------------------------------------------------------
  // Pointer registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage write; push is already qualified by rst_n through rdy_s
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= pld_s;
    end
  end

endmodule

// File: tb/tb_vrp_pld_fifo.sv
module tb_vrp_pld_fifo;

  localparam int DEPTH     = 4;
  localparam int PLD_WIDTH = 32;
  localparam int CW        = $clog2(DEPTH) + 1;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 vld_s;
  logic [PLD_WIDTH-1:0] pld_s;
  logic                 rdy_s;
  logic                 vld_m;
  logic [PLD_WIDTH-1:0] pld_m;
  logic                 rdy_m;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;

  vrp_pld_fifo #(
    .DEPTH    (DEPTH),
    .PLD_WIDTH(PLD_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vld_s(vld_s),
    .pld_s(pld_s),
    .rdy_s(rdy_s),
    .vld_m(vld_m),
    .pld_m(pld_m),
    .rdy_m(rdy_m),
    .count(count),
    .full (full),
    .empty(empty)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [PLD_WIDTH-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int max_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Inputs are already driven. Outputs are sampled 1ns
  // after the falling edge, well away from the rising edge. The reference
  // model decides acceptance and presentation from its own queue size.
  task automatic cycle(output bit acc, output bit popd);
    int sz;
    bit mvld;
    logic [PLD_WIDTH-1:0] f;
    #1;
    acc  = 1'b0;
    popd = 1'b0;
    sz   = exp_q.size();
    if (!rst_n) begin
      chk("rst_rdy_s", rdy_s, 0);
      chk("rst_vld_m", vld_m, 0);
      exp_q.delete();
    end else begin
      if (int'(count) > max_cnt) max_cnt = int'(count);
      chk("count", count, sz);
      chk("full",  full,  sz == DEPTH);
      chk("empty", empty, sz == 0);
      chk("rdy_s", rdy_s, sz < DEPTH);
`ifdef VRP_PLD_FIFO_BYPASS_EN
      mvld = (sz > 0) || vld_s;
`else
      mvld = (sz > 0);
`endif
      chk("vld_m", vld_m, mvld);
      if (vld_s && sz < DEPTH) begin
        exp_q.push_back(pld_s);
        acc = 1'b1;
      end
      if (rdy_m && mvld) begin
        if (exp_q.size() == 0) begin
          chk("pop_underflow", 1, 0);
        end else begin
          f = exp_q.pop_front();
          chk("pld_m", pld_m, f);
          popd = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin : main
    bit acc, popd;
    int sent, got, guard;

    rst_n = 1'b0;
    vld_s = 1'b1;
    pld_s = 32'hDEAD_BEEF;
    rdy_m = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles; nothing is accepted or presented.
    for (int i = 0; i < 3; i++) cycle(acc, popd);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    @(negedge clk);

    // First cycle after release: ready, nothing pending.
    rst_n = 1'b1;
    vld_s = 1'b0;
    rdy_m = 1'b0;
    cycle(acc, popd);

    // Basic transfer with rdy_m held high.
    vld_s = 1'b1;
    pld_s = 32'hA5A5_0001;
    rdy_m = 1'b1;
    cycle(acc, popd);
`ifdef VRP_PLD_FIFO_BYPASS_EN
    chk("basic_same_cycle", popd, 1);
`else
    chk("basic_no_same_cycle", popd, 0);
`endif
    vld_s = 1'b0;
    cycle(acc, popd);
`ifndef VRP_PLD_FIFO_BYPASS_EN
    chk("basic_next_cycle", popd, 1);
`endif
    cycle(acc, popd);

    // Fill to full, then a 5th beat is refused.
    rdy_m = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      vld_s = 1'b1;
      pld_s = PLD_WIDTH'(i);
      cycle(acc, popd);
    end
    pld_s = 32'd5;
    cycle(acc, popd);
    chk("fifth_refused", acc, 0);
    vld_s = 1'b0;
    rdy_m = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc, popd);
    rdy_m = 1'b0;
    cycle(acc, popd);
    #1;
    chk("drained_empty", empty, 1);
    @(negedge clk);

    // Full with simultaneous pop: count 4 -> 3 -> 4.
    for (int i = 0; i < 4; i++) begin
      vld_s = 1'b1;
      pld_s = 32'h10 + PLD_WIDTH'(i);
      cycle(acc, popd);
    end
    pld_s = 32'h20;
    rdy_m = 1'b1;
    cycle(acc, popd);
    chk("full_pop_no_push", acc, 0);
    chk("full_pop_popped", popd, 1);
    rdy_m = 1'b0;
    cycle(acc, popd);
    chk("after_pop_push", acc, 1);
    vld_s = 1'b0;
    cycle(acc, popd);
    rdy_m = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc, popd);
    rdy_m = 1'b0;
    cycle(acc, popd);

    // Wrap-around streaming: 20 beats, random rdy_m.
    sent = 0;
    got = 0;
    guard = 0;
    max_cnt = 0;
    while (got < 20 && guard < 400) begin
      vld_s = (sent < 20);
      pld_s = 32'h100 + PLD_WIDTH'(sent);
      rdy_m = 1'($urandom_range(0, 1));
      cycle(acc, popd);
      if (acc) sent++;
      if (popd) got++;
      guard++;
    end
    vld_s = 1'b0;
    rdy_m = 1'b0;
    chk("stream_sent", sent, 20);
    chk("stream_got", got, 20);
    chk("stream_max_count_le_depth", max_cnt <= DEPTH, 1);
    cycle(acc, popd);

    // Reset mid-operation with 3 entries stored.
    for (int i = 0; i < 3; i++) begin
      vld_s = 1'b1;
      pld_s = 32'h300 + PLD_WIDTH'(i);
      cycle(acc, popd);
    end
    vld_s = 1'b0;
    rst_n = 1'b0;
    cycle(acc, popd);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_vld_m", vld_m, 0);
    @(negedge clk);
    rdy_m = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc, popd);
    vld_s = 1'b1;
    pld_s = 32'h0BAD_F00D;
    cycle(acc, popd);
    vld_s = 1'b0;
    cycle(acc, popd);
    cycle(acc, popd);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
